// File: rtl/uart_fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fir_pkg
//  Description : Shared constants and types for the UART-to-FIR datapath.
//                Holds the sample width, FIFO depth and the inter-byte
//                timeout derived from the UART bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_fir_pkg;

  localparam int FIR_DATA_WIDTH   = 16;
  localparam int FIR_FIFO_DEPTH   = 4;
  localparam int CLKS_PER_BIT     = 1250;
  // Ten bit periods: one full UART character time of silence.
  localparam int FIR_TIMEOUT_CLKS = 10 * CLKS_PER_BIT;

  typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;

endpackage : uart_fir_pkg
`default_nettype wire

// File: rtl/uart_sample_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_assembler_if
//  Description : Byte-in / sample-out bundle of the sample assembler.
//                  i_rxdatval     byte strobe from the UART receiver
//                  i_rxbyte       received byte
//                  o_sample       FIFO head sample (first-word fall-through)
//                  o_sample_valid FIFO not empty
//                  i_sample_ready consumer accepts the head sample
//                Names carry the direction as seen from the assembler.
//                  master : upstream receiver + downstream consumer side
//                  slave  : the assembler itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_sample_assembler_if
  import uart_fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) ();

  logic                         i_rxdatval;
  logic [7:0]                   i_rxbyte;
  logic signed [DATA_WIDTH-1:0] o_sample;
  logic                         o_sample_valid;
  logic                         i_sample_ready;

  modport master (
    output i_rxdatval,
    output i_rxbyte,
    output i_sample_ready,
    input  o_sample,
    input  o_sample_valid
  );

  modport slave (
    input  i_rxdatval,
    input  i_rxbyte,
    input  i_sample_ready,
    output o_sample,
    output o_sample_valid
  );

endinterface : uart_sample_assembler_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO.
//                  i_clk, i_rst_n  clock, synchronous active-low reset
//                  i_wr_en/i_wr_data  push request and data
//                  i_rd_en            pop request (ignored when empty)
//                  o_rd_data          head entry, valid while !o_empty
//                  o_full/o_empty/o_count  occupancy status
//                A push while full is accepted only if a pop happens in the
//                same cycle. DEPTH must be a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import uart_fir_pkg::*;
#(
  parameter int WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_rd;
  logic w_do_wr;

  assign w_full  = (r_count == c_cw'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_do_rd = i_rd_en && !w_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Storage is cleared so the head output reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_sample_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_assembler
//  Description : Packs little-endian UART bytes into signed samples, buffers
//                them in a FWFT FIFO and hands them to the FIR core on a
//                valid/ready handshake. A partial sample left idle for
//                TIMEOUT_CLKS clocks is discarded with a frame-error pulse.
//                  i_clk, i_rst_n  clock, synchronous active-low reset
//                  bus (slave)     byte input and sample handshake
//                  o_fill          FIFO occupancy
//                  o_overflow      sticky: a completed sample was dropped
//                  o_frame_err     one-cycle pulse on timeout discard
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sample_assembler
  import uart_fir_pkg::*;
#(
  parameter int DATA_WIDTH       = FIR_DATA_WIDTH,
  parameter int BYTES_PER_SAMPLE = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH       = FIR_FIFO_DEPTH,
  parameter int TIMEOUT_CLKS     = FIR_TIMEOUT_CLKS
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  uart_sample_assembler_if.slave      bus,
  output logic [$clog2(FIFO_DEPTH):0] o_fill,
  output logic                        o_overflow,
  output logic                        o_frame_err
);

  localparam int c_idx_w = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int c_tmo_w = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BYTES_PER_SAMPLE - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CLKS - 1);

  logic [c_idx_w-1:0]    r_byte_idx;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic                  r_overflow;
  logic                  r_frame_err;

  logic                  w_last_byte;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_last_byte = (r_byte_idx == c_last_idx);
  assign w_push      = bus.i_rxdatval && w_last_byte;
  assign w_pop       = !w_empty && bus.i_sample_ready;

  // Completed word: the byte arriving now lands in the top lane, the lower
  // lanes come from the assembly register.
  always_comb begin
    w_word                    = r_asm;
    w_word[DATA_WIDTH-8 +: 8] = bus.i_rxbyte;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_byte_idx  <= '0;
      r_asm       <= '0;
      r_tmo_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (bus.i_rxdatval) begin
        // An accepted byte wins over a timeout expiring in the same cycle.
        r_tmo_cnt <= '0;
        for (int b = 0; b < BYTES_PER_SAMPLE; b++) begin
          if (r_byte_idx == c_idx_w'(b)) begin
            r_asm[8*b +: 8] <= bus.i_rxbyte;
          end
        end
        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + c_idx_w'(1);
      end else if (r_byte_idx != '0) begin
        if (r_tmo_cnt == c_tmo_last) begin
          r_byte_idx  <= '0;
          r_tmo_cnt   <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
      end

      // Dropped only when no slot is freed by a concurrent pop.
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_word),
    .i_rd_en   (bus.i_sample_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (o_fill)
  );

  assign bus.o_sample       = w_head;
  assign bus.o_sample_valid = !w_empty;
  assign o_overflow         = r_overflow;
  assign o_frame_err        = r_frame_err;

endmodule : uart_sample_assembler
`default_nettype wire

// File: tb/tb_uart_sample_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_sample_assembler
//  Description : Self-checking bench for uart_sample_assembler: a table of
//                two-byte samples with hand-computed results, followed by
//                directed sequences for handshake, timeout, overflow,
//                full-with-pop and mid-sample reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sample_assembler;
  import uart_fir_pkg::*;

  localparam int DW  = FIR_DATA_WIDTH;
  localparam int TMO = FIR_TIMEOUT_CLKS;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] fill;
  logic       overflow;
  logic       frame_err;
  logic [15:0] samp;

  int total  = 0;
  int bad    = 0;
  int fe_cnt = 0;
  logic [15:0] popped[$];

  uart_sample_assembler_if #(.DATA_WIDTH(DW)) bus ();

  uart_sample_assembler #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (4),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_fill      (fill),
    .o_overflow  (overflow),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  assign samp = bus.o_sample;

  // Record every completed handshake and every frame-error pulse.
  always @(posedge clk) begin
    if (rst_n && bus.o_sample_valid && bus.i_sample_ready) popped.push_back(samp);
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rxdatval = 1'b1;
    bus.i_rxbyte   = b;
    tick(1);
    bus.i_rxdatval = 1'b0;
  endtask

  task automatic pop_one();
    bus.i_sample_ready = 1'b1;
    tick(1);
    bus.i_sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int fe_before;

    bus.i_rxdatval     = 1'b0;
    bus.i_rxbyte       = 8'h00;
    bus.i_sample_ready = 1'b0;

    vecs[0] = '{8'h34, 8'h12, 16'h1234};
    vecs[1] = '{8'hFF, 8'h7F, 16'h7FFF};
    vecs[2] = '{8'h00, 8'h80, 16'h8000};
    vecs[3] = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[4] = '{8'h00, 8'h00, 16'h0000};
    vecs[5] = '{8'hCD, 8'hAB, 16'hABCD};

    // Reset state
    tick(2);
    chk("rst_valid", bus.o_sample_valid, 0);
    chk("rst_sample", samp, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick(1);

    // Table: assemble, check one-clock latency and value, then drain
    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].lo);
      chk("tbl_valid_partial", bus.o_sample_valid, 0);
      send_byte(vecs[v].hi);
      chk("tbl_valid", bus.o_sample_valid, 1);
      chk("tbl_sample", samp, vecs[v].exp);
      chk("tbl_fill", fill, 1);
      pop_one();
      chk("tbl_fill_after_pop", fill, 0);
      chk("tbl_valid_after_pop", bus.o_sample_valid, 0);
    end

    // Streaming with ready held high: two handshakes
    popped.delete();
    bus.i_sample_ready = 1'b1;
    send_byte(8'hFF);
    send_byte(8'h7F);
    chk("stream_first", samp, 16'h7FFF);
    send_byte(8'h00);
    send_byte(8'h80);
    chk("stream_second", samp, 16'h8000);
    tick(2);
    bus.i_sample_ready = 1'b0;
    chk("stream_count", popped.size(), 2);
    chk("stream_pop0", popped[0], 16'h7FFF);
    chk("stream_pop1", popped[1], 16'h8000);
    chk("stream_fill", fill, 0);
    chk("stream_overflow", overflow, 0);

    // Timeout discards a lone byte after TMO idle clocks
    fe_before = fe_cnt;
    send_byte(8'hAA);
    n = 0;
    for (int i = 1; i <= TMO + 50; i++) begin
      tick(1);
      if (frame_err) begin
        n = i;
        break;
      end
    end
    chk("tmo_latency", n, TMO);
    tick(1);
    chk("tmo_pulse_width", frame_err, 0);
    chk("tmo_pulse_count", fe_cnt - fe_before, 1);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("tmo_realign", samp, 16'h0001);
    pop_one();

    // Byte landing exactly in the timeout cycle is accepted, no error
    fe_before = fe_cnt;
    send_byte(8'h3C);
    tick(TMO - 1);
    send_byte(8'h5A);
    chk("tmo_prio_err", frame_err, 0);
    chk("tmo_prio_valid", bus.o_sample_valid, 1);
    chk("tmo_prio_sample", samp, 16'h5A3C);
    tick(2);
    chk("tmo_prio_no_pulse", fe_cnt - fe_before, 0);
    pop_one();

    // Overflow: five samples into a four-deep FIFO
    do_reset();
    popped.delete();
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k));
      send_byte(8'h00);
    end
    chk("ovf_fill", fill, 4);
    chk("ovf_flag", overflow, 1);
    bus.i_sample_ready = 1'b1;
    tick(6);
    bus.i_sample_ready = 1'b0;
    chk("ovf_drain_count", popped.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_data", popped[k], 16'(k + 1));
    end
    chk("ovf_empty", bus.o_sample_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Full FIFO with final byte coinciding with a pop
    do_reset();
    for (int k = 'h11; k <= 'h14; k++) begin
      send_byte(8'(k));
      send_byte(8'h00);
    end
    chk("fullpop_pre_fill", fill, 4);
    send_byte(8'h15);
    popped.delete();
    bus.i_sample_ready = 1'b1;
    send_byte(8'h00);
    bus.i_sample_ready = 1'b0;
    chk("fullpop_fill", fill, 4);
    chk("fullpop_overflow", overflow, 0);
    bus.i_sample_ready = 1'b1;
    tick(5);
    bus.i_sample_ready = 1'b0;
    chk("fullpop_count", popped.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("fullpop_order", popped[k], 16'('h11 + k));
    end

    // Reset mid-sample with a sample already buffered
    send_byte(8'h11);
    send_byte(8'h22);
    chk("midrst_pre_valid", bus.o_sample_valid, 1);
    fe_before = fe_cnt;
    send_byte(8'h99);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_valid", bus.o_sample_valid, 0);
    chk("midrst_sample", samp, 0);
    chk("midrst_fill", fill, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick(2);
    send_byte(8'h78);
    send_byte(8'h56);
    chk("midrst_sample_after", samp, 16'h5678);
    chk("midrst_fill_after", fill, 1);
    chk("midrst_no_err", fe_cnt - fe_before, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_sample_assembler
`default_nettype wire
